// File: rtl/led_pwm_fader.sv
`timescale 1ns/1ps
// Four-channel active-low LED output stage that fades each channel between dark and
// fully lit by ramping a per-channel PWM brightness level toward its target.
module led_pwm_fader #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 16
) (
    input  logic       osc_clk,
    input  logic       rst,
    input  logic [3:0] pattern_n,
    input  logic       enable,
    output logic [3:0] led_n,
    output logic       busy
);

    localparam int unsigned         SC_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [SC_W-1:0]     STEP_LAST = SC_W'(STEP_DIV - 1);

    logic [3:0]          r_pattern_q;
    logic                r_enable_q;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [SC_W-1:0]     r_step_cnt;
    logic [PWM_BITS-1:0] r_level [4];

    logic                w_frame_end;
    logic                w_step;
    logic [PWM_BITS-1:0] w_target    [4];
    logic [PWM_BITS-1:0] w_level_nxt [4];
    logic [3:0]          w_lit;
    logic [3:0]          w_diff;

    always_comb begin
        w_frame_end = (r_pwm_cnt == MAX);
        w_step      = w_frame_end && (r_step_cnt == STEP_LAST);
        w_lit       = '0;
        w_diff      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            // Targets come from the registered inputs, so a step coinciding with an
            // input change still moves toward the previous target.
            w_target[i]    = (r_enable_q && !r_pattern_q[i]) ? MAX : '0;
            w_level_nxt[i] = r_level[i];
            if (w_step) begin
                if (r_level[i] < w_target[i]) begin
                    w_level_nxt[i] = r_level[i] + 1'b1;
                end else if (r_level[i] > w_target[i]) begin
                    w_level_nxt[i] = r_level[i] - 1'b1;
                end
            end
            w_lit[i]  = (r_level[i] == MAX) || (r_level[i] > r_pwm_cnt);
            w_diff[i] = (r_level[i] != w_target[i]);
        end
    end

    always_ff @(posedge osc_clk) begin
        if (rst) begin
            r_pattern_q <= 4'hF;
            r_enable_q  <= 1'b0;
            r_pwm_cnt   <= '0;
            r_step_cnt  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_level[i] <= '0;
            end
            led_n <= 4'hF;
            busy  <= 1'b0;
        end else begin
            r_pattern_q <= pattern_n;
            r_enable_q  <= enable;
            r_pwm_cnt   <= r_pwm_cnt + 1'b1;
            if (w_frame_end) begin
                r_step_cnt <= w_step ? '0 : r_step_cnt + 1'b1;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                r_level[i] <= w_level_nxt[i];
            end
            led_n <= ~w_lit;
            busy  <= |w_diff;
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
`timescale 1ns/1ps
// Directed bench for led_pwm_fader with PWM_BITS=4, STEP_DIV=2 (16-cycle frame, step every 32 cycles).
module tb_led_pwm_fader;

    logic       osc_clk = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] pattern_n = 4'hF;
    logic       enable    = 1'b0;
    logic [3:0] led_n;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(2)) dut (
        .osc_clk   (osc_clk),
        .rst       (rst),
        .pattern_n (pattern_n),
        .enable    (enable),
        .led_n     (led_n),
        .busy      (busy)
    );

    always #5 osc_clk = ~osc_clk;

    // Each record starts on a step boundary; inputs are held for 'hold' step periods.
    // The lows window covers the second half of the last period, so it observes the
    // level after hold-1 steps; busy is sampled on the final edge of the record.
    typedef struct packed {
        logic [3:0]      pat;
        logic            en;
        logic [4:0]      hold;
        logic [3:0][4:0] lows;
        logic            busy;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic [3:0] p, input logic e, input int unsigned h,
                                input int unsigned l0, input int unsigned l1,
                                input int unsigned l2, input int unsigned l3, input logic b);
        vec_t v;
        v.pat     = p;
        v.en      = e;
        v.hold    = 5'(h);
        v.lows[0] = 5'(l0);
        v.lows[1] = 5'(l1);
        v.lows[2] = 5'(l2);
        v.lows[3] = 5'(l3);
        v.busy    = b;
        return v;
    endfunction

    task automatic tick;
        @(posedge osc_clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int unsigned n, input logic [3:0] p, input logic e);
        rst       = 1'b1;
        pattern_n = p;
        enable    = e;
        for (int unsigned k = 0; k < n; k++) begin
            tick();
            check($sformatf("reset_led_n_%0d", k), 32'(led_n), 32'hF);
            check($sformatf("reset_busy_%0d", k), 32'(busy), 32'h0);
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic count_lows(output int unsigned c0, output int unsigned c1,
                              output int unsigned c2, output int unsigned c3);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int unsigned k = 0; k < 16; k++) begin
            tick();
            if (led_n[0] == 1'b0) c0++;
            if (led_n[1] == 1'b0) c1++;
            if (led_n[2] == 1'b0) c2++;
            if (led_n[3] == 1'b0) c3++;
        end
    endtask

    task automatic run_vec(input int unsigned idx, input vec_t v);
        int unsigned c [4];
        pattern_n = v.pat;
        enable    = v.en;
        for (int unsigned k = 0; k < 32 * (int'(v.hold) - 1) + 16; k++) tick();
        count_lows(c[0], c[1], c[2], c[3]);
        for (int unsigned ch = 0; ch < 4; ch++) begin
            check($sformatf("vec%0d_ch%0d_lows", idx, ch), c[ch], 32'(v.lows[ch]));
        end
        check($sformatf("vec%0d_busy", idx), 32'(busy), 32'(v.busy));
    endtask

    initial begin
        int unsigned c0, c1, c2, c3;

        // fade-in of ch0, then reversal from level 7
        vecs[0]  = mk(4'hE, 1'b1,  1,  0,  0,  0,  0, 1'b1);
        vecs[1]  = mk(4'hE, 1'b1,  5,  5,  0,  0,  0, 1'b1);
        vecs[2]  = mk(4'hE, 1'b1,  1,  6,  0,  0,  0, 1'b1);
        vecs[3]  = mk(4'hF, 1'b1,  1,  7,  0,  0,  0, 1'b1);
        vecs[4]  = mk(4'hF, 1'b1,  3,  4,  0,  0,  0, 1'b1);
        vecs[5]  = mk(4'hF, 1'b1,  3,  1,  0,  0,  0, 1'b1);
        vecs[6]  = mk(4'hF, 1'b1,  1,  0,  0,  0,  0, 1'b0);
        // rotating one-hot, 64 cycles per position
        vecs[7]  = mk(4'hE, 1'b1,  2,  1,  0,  0,  0, 1'b1);
        vecs[8]  = mk(4'hD, 1'b1,  2,  1,  1,  0,  0, 1'b1);
        vecs[9]  = mk(4'hB, 1'b1,  2,  0,  1,  1,  0, 1'b1);
        vecs[10] = mk(4'h7, 1'b1,  2,  0,  0,  1,  1, 1'b1);
        // all on; every channel saturates at MAX
        vecs[11] = mk(4'h0, 1'b1, 16, 16, 16, 16, 16, 1'b0);

        // reset with inputs requesting all on
        do_reset(3, 4'h0, 1'b1);
        tick();
        check("post_reset_led_n", 32'(led_n), 32'hF);
        check("post_reset_busy", 32'(busy), 32'h0);
        tick();
        check("busy_latency", 32'(busy), 32'h1);
        check("busy_latency_led_n", 32'(led_n), 32'hF);

        do_reset(2, 4'hF, 1'b0);
        for (int unsigned i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // enable drop from all at MAX: lockstep fade out over 15 steps
        enable = 1'b0;
        repeat (32 * 14) tick();
        tick();
        check("drop_lit_at_level1", 32'(led_n), 32'h0);
        repeat (31) tick();
        check("drop_busy_on_last_step", 32'(busy), 32'h1);
        tick();
        check("drop_busy_after_last_step", 32'(busy), 32'h0);
        check("drop_dark", 32'(led_n), 32'hF);

        // reset in the middle of a fade at level 9
        do_reset(1, 4'hF, 1'b0);
        pattern_n = 4'hE;
        enable    = 1'b1;
        repeat (32 * 9) tick();
        count_lows(c0, c1, c2, c3);
        check("midreset_level9_lows", c0, 32'd9);
        rst = 1'b1;
        tick();
        check("midreset_led_n", 32'(led_n), 32'hF);
        check("midreset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        cyc = 0;
        count_lows(c0, c1, c2, c3);
        check("restart_level0_lows", c0, 32'd0);
        repeat (16) tick();
        count_lows(c0, c1, c2, c3);
        check("restart_level1_lows", c0, 32'd1);
        check("restart_ch3_dark", c3, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
